// File: rtl/cpu_run_controller_if.sv
// Bus between the run controller and whatever hosts it (board logic or a bench).
//   start      host -> ctrl   run request, sampled in IDLE/DONE
//   cpu_out    host -> ctrl   CPU output bus being watched and traced
//   rd_addr    host -> ctrl   trace read address
//   cpu_reset  ctrl -> host   active-low reset for cpu_top
//   busy/done  ctrl -> host   run phase indication
//   halted/timeout/overflow   ctrl -> host   how the run ended / trace lost data
//   cycle_cnt  ctrl -> host   run cycles elapsed
//   trace_cnt  ctrl -> host   valid trace entries
//   rd_data    ctrl -> host   trace entry at rd_addr, one cycle after the address
// The controller connects through the slave modport, the host through master.
interface cpu_run_controller_if #(
    parameter int WIDTH       = 16,
    parameter int MAX_CYCLES  = 20,
    parameter int TRACE_DEPTH = 16
);
    logic                               start;
    logic [WIDTH-1:0]                   cpu_out;
    logic [$clog2(TRACE_DEPTH)-1:0]     rd_addr;
    logic                               cpu_reset;
    logic                               busy;
    logic                               done;
    logic                               halted;
    logic                               timeout;
    logic                               overflow;
    logic [$clog2(MAX_CYCLES+1)-1:0]    cycle_cnt;
    logic [$clog2(TRACE_DEPTH+1)-1:0]   trace_cnt;
    logic [WIDTH-1:0]                   rd_data;

    modport master (
        output start, cpu_out, rd_addr,
        input  cpu_reset, busy, done, halted, timeout, overflow, cycle_cnt, trace_cnt, rd_data
    );

    modport slave (
        input  start, cpu_out, rd_addr,
        output cpu_reset, busy, done, halted, timeout, overflow, cycle_cnt, trace_cnt, rd_data
    );
endinterface

// File: rtl/cpu_run_controller.sv
// Run harness for cpu_top: holds the CPU in reset for RESET_CYCLES, lets it run for at
// most MAX_CYCLES, stops early once cpu_out has been unchanged for HALT_STABLE cycles,
// and records every change of cpu_out into a TRACE_DEPTH-entry buffer.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset; aborts any run immediately
//   bus    cpu_run_controller_if.slave (start, cpu_out, rd_addr in; status, counters,
//          cpu_reset and rd_data out)
module cpu_run_controller #(
    parameter int WIDTH        = 16,
    parameter int RESET_CYCLES = 2,
    parameter int MAX_CYCLES   = 20,
    parameter int HALT_STABLE  = 4,
    parameter int TRACE_DEPTH  = 16,
    parameter bit AUTO_START   = 1'b1
) (
    input logic             clk,
    input logic             reset,
    cpu_run_controller_if.slave bus
);
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam int TW = $clog2(TRACE_DEPTH + 1);
    localparam int AW = $clog2(TRACE_DEPTH);
    localparam int HW = $clog2(RESET_CYCLES + 1);
    localparam int SW = $clog2(HALT_STABLE + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HOLD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
    logic [CW-1:0]    cycle_cnt_q, cycle_cnt_d;
    logic [TW-1:0]    trace_cnt_q, trace_cnt_d;
    logic [SW-1:0]    stable_q, stable_d;
    logic             halted_q, halted_d;
    logic             timeout_q, timeout_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic [WIDTH-1:0] mem_q [TRACE_DEPTH];

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic             record;
    logic [SW-1:0]    stable_now;
    logic [CW-1:0]    cycle_next;

    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        trace_cnt_d = trace_cnt_q;
        stable_d    = stable_q;
        halted_d    = halted_q;
        timeout_d   = timeout_q;
        overflow_d  = overflow_q;
        prev_d      = prev_q;
        wr_en       = 1'b0;
        wr_addr     = trace_cnt_q[AW-1:0];
        // cycle_cnt is still zero during the first RUN cycle, so that cycle always records
        // and restarts the stability count regardless of the stale previous sample.
        record      = (cycle_cnt_q == '0) || (bus.cpu_out != prev_q);
        stable_now  = record ? SW'(1) : stable_q + SW'(1);
        cycle_next  = cycle_cnt_q + CW'(1);
        rd_data_d   = mem_q[bus.rd_addr];

        case (state_q)
            S_IDLE, S_DONE: begin
                // IDLE is only ever entered from reset, so AUTO_START leaves it on the
                // first cycle after reset release.
                if ((state_q == S_IDLE && AUTO_START) || bus.start) begin
                    state_d     = S_HOLD;
                    hold_cnt_d  = '0;
                    cycle_cnt_d = '0;
                    trace_cnt_d = '0;
                    stable_d    = '0;
                    halted_d    = 1'b0;
                    timeout_d   = 1'b0;
                    overflow_d  = 1'b0;
                end
            end
            S_HOLD: begin
                if (hold_cnt_q == HW'(RESET_CYCLES - 1)) begin
                    state_d = S_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            S_RUN: begin
                cycle_cnt_d = cycle_next;
                stable_d    = stable_now;
                prev_d      = bus.cpu_out;
                if (record) begin
                    if (trace_cnt_q == TW'(TRACE_DEPTH)) begin
                        overflow_d = 1'b1;
                    end else begin
                        wr_en       = 1'b1;
                        trace_cnt_d = trace_cnt_q + TW'(1);
                    end
                end
                // Halt and timeout are evaluated independently so both flags can be set
                // when they coincide.
                if (stable_now == SW'(HALT_STABLE)) begin
                    halted_d = 1'b1;
                    state_d  = S_DONE;
                end
                if (cycle_next == CW'(MAX_CYCLES)) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            hold_cnt_q  <= '0;
            cycle_cnt_q <= '0;
            trace_cnt_q <= '0;
            stable_q    <= '0;
            halted_q    <= 1'b0;
            timeout_q   <= 1'b0;
            overflow_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
            trace_cnt_q <= trace_cnt_d;
            stable_q    <= stable_d;
            halted_q    <= halted_d;
            timeout_q   <= timeout_d;
            overflow_q  <= overflow_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // Trace storage and the previous-sample register carry data only; the read above
    // sees the pre-write contents, so a same-cycle write/read returns old data.
    always_ff @(posedge clk) begin
        prev_q <= prev_d;
        if (wr_en) begin
            mem_q[wr_addr] <= bus.cpu_out;
        end
    end

    // cpu_reset is released for RUN and kept released in DONE so the CPU state survives.
    assign bus.cpu_reset = (state_q == S_RUN) || (state_q == S_DONE);
    assign bus.busy      = (state_q == S_HOLD) || (state_q == S_RUN);
    assign bus.done      = (state_q == S_DONE);
    assign bus.halted    = halted_q;
    assign bus.timeout   = timeout_q;
    assign bus.overflow  = overflow_q;
    assign bus.cycle_cnt = cycle_cnt_q;
    assign bus.trace_cnt = trace_cnt_q;
    assign bus.rd_data   = rd_data_q;
endmodule

// File: tb/tb_cpu_run_controller.sv
// Bench for cpu_run_controller. Two instances: A with default parameters (auto start),
// B with MAX_CYCLES=4 and AUTO_START=0. A run-level model predicts every status output
// from the stimulus; directed literal checks pin the model to hand-derived values.
module tb_cpu_run_controller;
    localparam int R     = 2;
    localparam int H     = 4;
    localparam int DEPTH = 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    cpu_run_controller_if #(.WIDTH(16), .MAX_CYCLES(20), .TRACE_DEPTH(16)) ifa ();
    cpu_run_controller_if #(.WIDTH(16), .MAX_CYCLES(4),  .TRACE_DEPTH(16)) ifb ();

    cpu_run_controller #(.WIDTH(16), .RESET_CYCLES(2), .MAX_CYCLES(20), .HALT_STABLE(4),
                         .TRACE_DEPTH(16), .AUTO_START(1'b1))
        dut_a (.clk(clk), .reset(reset), .bus(ifa));

    cpu_run_controller #(.WIDTH(16), .RESET_CYCLES(2), .MAX_CYCLES(4), .HALT_STABLE(4),
                         .TRACE_DEPTH(16), .AUTO_START(1'b0))
        dut_b (.clk(clk), .reset(reset), .bus(ifb));

    // stimulus per instance (index 0 = A, 1 = B)
    logic        start_v [2];
    logic [15:0] cout_v  [2];
    logic [3:0]  rda_v   [2];

    assign ifa.start = start_v[0];  assign ifa.cpu_out = cout_v[0];  assign ifa.rd_addr = rda_v[0];
    assign ifb.start = start_v[1];  assign ifb.cpu_out = cout_v[1];  assign ifb.rd_addr = rda_v[1];

    logic        o_crst [2], o_busy [2], o_done [2], o_halt [2], o_tmo [2], o_ovf [2];
    logic [31:0] o_cyc [2], o_tcnt [2];
    logic [15:0] o_rd [2];

    assign o_crst[0] = ifa.cpu_reset;  assign o_crst[1] = ifb.cpu_reset;
    assign o_busy[0] = ifa.busy;       assign o_busy[1] = ifb.busy;
    assign o_done[0] = ifa.done;       assign o_done[1] = ifb.done;
    assign o_halt[0] = ifa.halted;     assign o_halt[1] = ifb.halted;
    assign o_tmo[0]  = ifa.timeout;    assign o_tmo[1]  = ifb.timeout;
    assign o_ovf[0]  = ifa.overflow;   assign o_ovf[1]  = ifb.overflow;
    assign o_cyc[0]  = 32'(ifa.cycle_cnt);  assign o_cyc[1]  = 32'(ifb.cycle_cnt);
    assign o_tcnt[0] = 32'(ifa.trace_cnt);  assign o_tcnt[1] = 32'(ifb.trace_cnt);
    assign o_rd[0]   = ifa.rd_data;    assign o_rd[1]   = ifb.rd_data;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(string name, int d, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: actual %0d required %0d at %0t", name, d, act, exp, $time);
        end
    endtask

    // ---------------- run-level model ----------------
    // A run is counted in clock edges k since the edge that accepted the trigger:
    // the first R edges finish the reset hold, every later edge finishes one run cycle
    // and takes one cpu_out sample. Outcomes derive from the sample history.
    bit          m_active [2], m_ran [2], m_auto [2];
    int          m_k [2], m_i [2], m_tcnt [2];
    bit          m_ovf [2], m_halt [2], m_tmo [2];
    logic [15:0] m_samp  [2][32];
    logic [15:0] m_trace [2][16];

    function automatic int max_of(int d);
        return (d == 0) ? 20 : 4;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_active[d] = 1'b0;  m_ran[d] = 1'b0;  m_auto[d] = (d == 0);
            m_k[d] = 0;  m_i[d] = 0;  m_tcnt[d] = 0;
            m_ovf[d] = 1'b0;  m_halt[d] = 1'b0;  m_tmo[d] = 1'b0;
        end
    endtask

    task automatic model_step(int d);
        int i;
        bit same;
        if (!m_active[d]) begin
            if (start_v[d] || m_auto[d]) begin
                m_active[d] = 1'b1;  m_ran[d] = 1'b1;  m_auto[d] = 1'b0;
                m_k[d] = 0;  m_i[d] = 0;  m_tcnt[d] = 0;
                m_ovf[d] = 1'b0;  m_halt[d] = 1'b0;  m_tmo[d] = 1'b0;
            end
        end else begin
            m_k[d]++;
            if (m_k[d] > R) begin
                m_i[d]++;
                i = m_i[d];
                m_samp[d][i] = cout_v[d];
                if (i == 1 || m_samp[d][i] != m_samp[d][i-1]) begin
                    if (m_tcnt[d] < DEPTH) begin
                        m_trace[d][m_tcnt[d]] = cout_v[d];
                        m_tcnt[d]++;
                    end else begin
                        m_ovf[d] = 1'b1;
                    end
                end
                // halted once the last H samples are all identical
                same = (i >= H);
                if (same) begin
                    for (int j = i - H + 1; j < i; j++)
                        if (m_samp[d][j] != m_samp[d][i]) same = 1'b0;
                end
                if (same) m_halt[d] = 1'b1;
                if (i == max_of(d)) m_tmo[d] = 1'b1;
                if (m_halt[d] || m_tmo[d]) m_active[d] = 1'b0;
            end
        end
    endtask

    task automatic compare(int d);
        logic exp_crst;
        exp_crst = m_active[d] ? (m_k[d] >= R) : m_ran[d];
        chk("cpu_reset", d, 32'(o_crst[d]), 32'(exp_crst));
        chk("busy",      d, 32'(o_busy[d]), 32'(m_active[d]));
        chk("done",      d, 32'(o_done[d]), 32'(!m_active[d] && m_ran[d]));
        chk("halted",    d, 32'(o_halt[d]), 32'(m_halt[d]));
        chk("timeout",   d, 32'(o_tmo[d]),  32'(m_tmo[d]));
        chk("overflow",  d, 32'(o_ovf[d]),  32'(m_ovf[d]));
        chk("cycle_cnt", d, o_cyc[d],       32'(m_i[d]));
        chk("trace_cnt", d, o_tcnt[d],      32'(m_tcnt[d]));
    endtask

    initial begin : model_and_compare
        model_reset();
        forever begin
            @(posedge clk);
            if (!reset) model_reset();
            else for (int d = 0; d < 2; d++) model_step(d);
            #1;
            for (int d = 0; d < 2; d++) compare(d);
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [15:0] pat [40];
    int          pat_len;

    // Presents pat[j] for the j-th edge from now; with_start pulses start on edge 0.
    task automatic play(int d, bit with_start);
        for (int j = 0; j < pat_len; j++) begin
            cout_v[d]  = pat[j];
            start_v[d] = with_start && (j == 0);
            @(negedge clk);
        end
        start_v[d] = 1'b0;
    endtask

    task automatic wait_done(int d, int budget);
        int n;
        n = 0;
        while (!o_done[d] && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_within_budget", d, 32'(o_done[d]), 32'd1);
    endtask

    task automatic read_chk(int d, int a, logic [15:0] exp);
        rda_v[d] = 4'(a);
        @(negedge clk);
        chk("rd_data", d, 32'(o_rd[d]), 32'(exp));
    endtask

    task automatic check_trace(int d);
        for (int a = 0; a < m_tcnt[d]; a++) read_chk(d, a, m_trace[d][a]);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int hold_n;
        start_v[0] = 1'b0;  start_v[1] = 1'b0;
        cout_v[0]  = '0;    cout_v[1]  = '0;
        rda_v[0]   = '0;    rda_v[1]   = '0;
        repeat (3) @(negedge clk);

        // reset values
        chk("rst_cpu_reset", 0, 32'(o_crst[0]), 32'd0);
        chk("rst_busy",      0, 32'(o_busy[0]), 32'd0);
        chk("rst_cycle_cnt", 0, o_cyc[0],       32'd0);
        chk("rst_rd_data",   0, 32'(o_rd[0]),   32'd0);

        // 1: auto start, constant 0x0005 -> halt after 4 run cycles
        reset     = 1'b1;
        cout_v[0] = 16'h0005;
        hold_n    = 0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (o_busy[0] && !o_crst[0]) hold_n++;
        end
        chk("t1_hold_cycles", 0, 32'(hold_n), 32'd2);
        wait_done(0, 40);
        chk("t1_halted",    0, 32'(o_halt[0]), 32'd1);
        chk("t1_timeout",   0, 32'(o_tmo[0]),  32'd0);
        chk("t1_trace_cnt", 0, o_tcnt[0],      32'd1);
        chk("t1_cycle_cnt", 0, o_cyc[0],       32'd4);
        read_chk(0, 0, 16'h0005);
        chk("b_idle_cpu_reset", 1, 32'(o_crst[1]), 32'd0);
        chk("b_idle_busy",      1, 32'(o_busy[1]), 32'd0);

        // 2: incrementing bus -> timeout at 20, trace full, overflow
        pat_len = 30;
        for (int j = 0; j < 30; j++) pat[j] = 16'(100 + j);
        play(0, 1'b1);
        wait_done(0, 40);
        chk("t2_timeout",   0, 32'(o_tmo[0]),  32'd1);
        chk("t2_halted",    0, 32'(o_halt[0]), 32'd0);
        chk("t2_cycle_cnt", 0, o_cyc[0],       32'd20);
        chk("t2_trace_cnt", 0, o_tcnt[0],      32'd16);
        chk("t2_overflow",  0, 32'(o_ovf[0]),  32'd1);
        read_chk(0, 0, 16'd103);
        read_chk(0, 15, 16'd118);
        check_trace(0);

        // 3: run samples 1,1,2,2,2,2 -> trace {1,2}, halt on the 6th cycle
        pat_len = 12;
        for (int j = 0; j < 12; j++) pat[j] = (j < 5) ? 16'd1 : 16'd2;
        play(0, 1'b1);
        wait_done(0, 40);
        chk("t3_halted",    0, 32'(o_halt[0]), 32'd1);
        chk("t3_timeout",   0, 32'(o_tmo[0]),  32'd0);
        chk("t3_trace_cnt", 0, o_tcnt[0],      32'd2);
        chk("t3_cycle_cnt", 0, o_cyc[0],       32'd6);
        read_chk(0, 0, 16'd1);
        read_chk(0, 1, 16'd2);

        // 4: B (MAX_CYCLES=4), constant -> halt and timeout together
        pat_len = 10;
        for (int j = 0; j < 10; j++) pat[j] = 16'd7;
        play(1, 1'b1);
        wait_done(1, 40);
        chk("t4_halted",    1, 32'(o_halt[1]), 32'd1);
        chk("t4_timeout",   1, 32'(o_tmo[1]),  32'd1);
        chk("t4_cycle_cnt", 1, o_cyc[1],       32'd4);
        chk("t4_trace_cnt", 1, o_tcnt[1],      32'd1);

        // 5: start pulse during RUN is ignored; pulse in DONE reruns and clears flags
        pat_len = 13;
        for (int j = 0; j < 13; j++) pat[j] = 16'(200 + j);
        start_v[1] = 1'b1;
        cout_v[1]  = pat[0];
        for (int j = 1; j < 13; j++) begin
            @(negedge clk);
            cout_v[1]  = pat[j];
            start_v[1] = (j == 4);
        end
        start_v[1] = 1'b0;
        wait_done(1, 40);
        chk("t5_timeout",   1, 32'(o_tmo[1]),  32'd1);
        chk("t5_halted",    1, 32'(o_halt[1]), 32'd0);
        chk("t5_trace_cnt", 1, o_tcnt[1],      32'd4);
        read_chk(1, 0, 16'd203);
        start_v[1] = 1'b1;
        cout_v[1]  = 16'd9;
        @(negedge clk);
        start_v[1] = 1'b0;
        chk("t5_rerun_busy",      1, 32'(o_busy[1]), 32'd1);
        chk("t5_rerun_cpu_reset", 1, 32'(o_crst[1]), 32'd0);
        chk("t5_rerun_timeout",   1, 32'(o_tmo[1]),  32'd0);
        chk("t5_rerun_trace_cnt", 1, o_tcnt[1],      32'd0);
        wait_done(1, 40);
        chk("t5_rerun_halted",    1, 32'(o_halt[1]), 32'd1);

        // 6: reset asserted mid-run between clock edges, then a fresh auto run
        start_v[0] = 1'b1;
        cout_v[0]  = 16'd300;
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            start_v[0] = 1'b0;
            cout_v[0]  = 16'(300 + j);
        end
        #2;
        reset = 1'b0;
        #1;
        chk("t6_cpu_reset", 0, 32'(o_crst[0]), 32'd0);
        chk("t6_busy",      0, 32'(o_busy[0]), 32'd0);
        chk("t6_done",      0, 32'(o_done[0]), 32'd0);
        chk("t6_cycle_cnt", 0, o_cyc[0],       32'd0);
        chk("t6_trace_cnt", 0, o_tcnt[0],      32'd0);
        chk("t6_rd_data",   0, 32'(o_rd[0]),   32'd0);
        chk("t6_b_done",    1, 32'(o_done[1]), 32'd0);
        repeat (2) @(negedge clk);
        reset     = 1'b1;
        cout_v[0] = 16'h0042;
        wait_done(0, 40);
        chk("t6_halted",    0, 32'(o_halt[0]), 32'd1);
        chk("t6_cycle_cnt2", 0, o_cyc[0],      32'd4);
        read_chk(0, 0, 16'h0042);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
